// File: rtl/red_reduce_seq.sv
// red_reduce_seq: multi-cycle lane-sum reduction of two operands with signed/unsigned lanes
module red_reduce_seq #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sgn,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result
);
    localparam int NUM_LANES = DATA_W / LANE_W;
    localparam int ACC_W     = LANE_W + 1 + $clog2(NUM_LANES);
    localparam int IDX_W     = $clog2(NUM_LANES + 1);

    generate
        if (ACC_W > DATA_W || NUM_LANES < 2 || DATA_W % LANE_W != 0) begin : g_bad_params
            $error("red_reduce_seq: unsupported DATA_W/LANE_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic                sgn_q, sgn_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0]    lane_a, lane_b;

    // Operands are shifted right each add, so the current lane is always the low slice.
    assign lane_a = sgn_q ? ACC_W'($signed(a_q[LANE_W-1:0])) : ACC_W'(a_q[LANE_W-1:0]);
    assign lane_b = sgn_q ? ACC_W'($signed(b_q[LANE_W-1:0])) : ACC_W'(b_q[LANE_W-1:0]);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    // Next-state: capture in IDLE, one lane pair per ACCUM cycle plus a final extend cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = sgn;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == IDX_W'(NUM_LANES)) begin
                    result_d = sgn_q ? DATA_W'($signed(acc_q)) : DATA_W'(acc_q);
                    state_d  = DONE;
                end else begin
                    acc_d = acc_q + lane_a + lane_b;
                    a_d   = a_q >> LANE_W;
                    b_d   = b_q >> LANE_W;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = (abort || out_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end
endmodule
